// File: rtl/regfile_lvt_fpga_if.sv
// Register-file access bundle: read/write ports, clear request and init status.
// master drives addresses/data, slave is the register file.
interface regfile_lvt_fpga_if #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned NR_READ_PORTS  = 2
) ();
    localparam int unsigned AW = $clog2(DEPTH);

    logic                                           clear_i;
    logic                                           init_done_o;
    logic [NR_READ_PORTS-1:0][AW-1:0]               raddr_i;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]       rdata_o;
    logic [NR_WRITE_PORTS-1:0][AW-1:0]              waddr_i;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]      wdata_i;
    logic [NR_WRITE_PORTS-1:0]                      we_i;

    modport master (
        output clear_i,
        output raddr_i,
        output waddr_i,
        output wdata_i,
        output we_i,
        input  init_done_o,
        input  rdata_o
    );

    modport slave (
        input  clear_i,
        input  raddr_i,
        input  waddr_i,
        input  wdata_i,
        input  we_i,
        output init_done_o,
        output rdata_o
    );
endinterface

// File: rtl/regfile_lvt_fpga.sv
// Multi-ported FPGA register file: one distributed-RAM bank per write port,
// a live-value table selecting the newest bank, and a hardware scrubber.
module regfile_lvt_fpga #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter bit          SYNC_READ      = 1'b0,
    parameter bit          ZERO_REG_ZERO  = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    regfile_lvt_fpga_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW =
        (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1;

    typedef enum logic {
        SCRUB,
        READY
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic [AW-1:0]           cnt_q;
    logic [AW-1:0]           cnt_d;
    logic                    init_done;
    logic                    scrub_we;
    logic [NR_WRITE_PORTS-1:0] wq;
    logic [LW-1:0]           lvt_q [DEPTH];

    logic [NR_WRITE_PORTS-1:0][NR_READ_PORTS-1:0][DATA_WIDTH-1:0] bank_rd;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_comb;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SCRUB;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SCRUB: begin
                if (bus.clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            READY: begin
                if (bus.clear_i) begin
                    state_d = SCRUB;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        init_done = 1'b0;
        scrub_we  = 1'b0;
        unique case (state_q)
            SCRUB:   scrub_we  = 1'b1;
            READY:   init_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.init_done_o = init_done;

    always_comb begin
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            wq[j] = bus.we_i[j] && init_done &&
                    !(ZERO_REG_ZERO && (bus.waddr_i[j] == '0));
        end
    end

    // Banks carry no reset; the scrubber zeroes bank 0 and the LVT points there.
    for (genvar j = 0; j < NR_WRITE_PORTS; j++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic                  scrub_bank;

        assign scrub_bank = (j == 0) && scrub_we;

        always_ff @(posedge clk_i) begin
            if (scrub_bank) begin
                mem[cnt_q] <= '0;
            end else if (wq[j]) begin
                mem[bus.waddr_i[j]] <= bus.wdata_i[j];
            end
        end

        for (genvar k = 0; k < NR_READ_PORTS; k++) begin : g_rd
            assign bank_rd[j][k] = mem[bus.raddr_i[k]];
        end
    end

    // Ascending loop: the highest colliding port owns the entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                lvt_q[i] <= '0;
            end
        end else if (scrub_we) begin
            lvt_q[cnt_q] <= '0;
        end else begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (wq[j]) begin
                    lvt_q[bus.waddr_i[j]] <= LW'(j);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NR_READ_PORTS; k++) begin
            rd_comb[k] = '0;
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (lvt_q[bus.raddr_i[k]] == LW'(j)) begin
                    rd_comb[k] = bank_rd[j][k];
                end
            end
            if (!init_done ||
                (ZERO_REG_ZERO && (bus.raddr_i[k] == '0))) begin
                rd_comb[k] = '0;
            end
        end
    end

    if (SYNC_READ) begin : g_sync
        logic [NR_READ_PORTS-1:0]                 hit_d;
        logic [NR_READ_PORTS-1:0]                 hit_q;
        logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] byp_d;
        logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] byp_q;
        logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_q;

        // Same-edge write to the sampled address wins over the stale bank read.
        always_comb begin
            for (int k = 0; k < NR_READ_PORTS; k++) begin
                hit_d[k] = 1'b0;
                byp_d[k] = '0;
                for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                    if (wq[j] && (bus.waddr_i[j] == bus.raddr_i[k])) begin
                        hit_d[k] = 1'b1;
                        byp_d[k] = bus.wdata_i[j];
                    end
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hit_q <= '0;
                byp_q <= '0;
                rd_q  <= '0;
            end else begin
                hit_q <= hit_d;
                byp_q <= byp_d;
                rd_q  <= rd_comb;
            end
        end

        always_comb begin
            for (int k = 0; k < NR_READ_PORTS; k++) begin
                rdata[k] = '0;
                if (init_done) begin
                    rdata[k] = hit_q[k] ? byp_q[k] : rd_q[k];
                end
            end
        end
    end else begin : g_comb
        assign rdata = rd_comb;
    end

    assign bus.rdata_o = rdata;

endmodule

// File: tb/tb_regfile_lvt_fpga.sv
// Directed bench for regfile_lvt_fpga: three instances covering
// combinational read, registered read with bypass, and hard-wired entry 0.
module tb_regfile_lvt_fpga;
    logic clk;
    logic rst_n;
    logic clear;
    logic [1:0][4:0]  raddr;
    logic [1:0][4:0]  waddr;
    logic [1:0][63:0] wdata;
    logic [1:0]       we;

    int n_vec = 0;
    int n_err = 0;

    regfile_lvt_fpga_if #(.DATA_WIDTH(64), .DEPTH(32),
        .NR_WRITE_PORTS(2), .NR_READ_PORTS(2)) bus0 ();
    regfile_lvt_fpga_if #(.DATA_WIDTH(64), .DEPTH(32),
        .NR_WRITE_PORTS(2), .NR_READ_PORTS(2)) bus1 ();
    regfile_lvt_fpga_if #(.DATA_WIDTH(64), .DEPTH(32),
        .NR_WRITE_PORTS(2), .NR_READ_PORTS(2)) bus2 ();

    assign bus0.clear_i = clear;
    assign bus0.raddr_i = raddr;
    assign bus0.waddr_i = waddr;
    assign bus0.wdata_i = wdata;
    assign bus0.we_i    = we;
    assign bus1.clear_i = clear;
    assign bus1.raddr_i = raddr;
    assign bus1.waddr_i = waddr;
    assign bus1.wdata_i = wdata;
    assign bus1.we_i    = we;
    assign bus2.clear_i = clear;
    assign bus2.raddr_i = raddr;
    assign bus2.waddr_i = waddr;
    assign bus2.wdata_i = wdata;
    assign bus2.we_i    = we;

    regfile_lvt_fpga #(.SYNC_READ(1'b0), .ZERO_REG_ZERO(1'b0)) u_comb (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus0)
    );

    regfile_lvt_fpga #(.SYNC_READ(1'b1), .ZERO_REG_ZERO(1'b0)) u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    regfile_lvt_fpga #(.SYNC_READ(1'b0), .ZERO_REG_ZERO(1'b1)) u_zero (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scrub_wait(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_busy_c"}, 64'(bus0.init_done_o), 64'd0);
            chk({tag, "_busy_s"}, 64'(bus1.init_done_o), 64'd0);
            chk({tag, "_gate_c"}, bus0.rdata_o[0], 64'd0);
            chk({tag, "_gate_s"}, bus1.rdata_o[0], 64'd0);
            tick();
        end
        chk({tag, "_done_c"}, 64'(bus0.init_done_o), 64'd1);
        chk({tag, "_done_s"}, 64'(bus1.init_done_o), 64'd1);
        chk({tag, "_done_z"}, 64'(bus2.init_done_o), 64'd1);
    endtask

    task automatic readback_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(31 - a);
            tick();
            chk({tag, "_c0"}, bus0.rdata_o[0], 64'd0);
            chk({tag, "_c1"}, bus0.rdata_o[1], 64'd0);
            chk({tag, "_s0"}, bus1.rdata_o[0], 64'd0);
            chk({tag, "_s1"}, bus1.rdata_o[1], 64'd0);
            chk({tag, "_z0"}, bus2.rdata_o[0], 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        we    = '0;

        repeat (3) tick();
        chk("rst_done_c", 64'(bus0.init_done_o), 64'd0);
        chk("rst_done_s", 64'(bus1.init_done_o), 64'd0);
        chk("rst_rd_c", bus0.rdata_o[0], 64'd0);
        chk("rst_rd_s", bus1.rdata_o[1], 64'd0);

        rst_n = 1'b1;
        scrub_wait("rst");
        readback_zero("post_rst");

        raddr[0] = 5'd5;
        we       = 2'b01;
        waddr[0] = 5'd5;
        wdata[0] = 64'hAAAA;
        #1;
        chk("no_write_through", bus0.rdata_o[0], 64'd0);
        tick();
        we       = 2'b10;
        waddr[1] = 5'd5;
        wdata[1] = 64'hBBBB;
        #1;
        chk("p0_wr_c", bus0.rdata_o[0], 64'hAAAA);
        chk("p0_wr_s", bus1.rdata_o[0], 64'hAAAA);
        tick();
        we = 2'b00;
        #1;
        chk("p1_wr_c", bus0.rdata_o[0], 64'hBBBB);
        chk("p1_wr_s", bus1.rdata_o[0], 64'hBBBB);

        raddr[1] = 5'd7;
        we       = 2'b11;
        waddr[0] = 5'd7;
        waddr[1] = 5'd7;
        wdata[0] = 64'h1;
        wdata[1] = 64'h2;
        tick();
        we = 2'b00;
        #1;
        chk("collide_c", bus0.rdata_o[1], 64'h2);
        chk("collide_s", bus1.rdata_o[1], 64'h2);
        chk("collide_z", bus2.rdata_o[1], 64'h2);

        raddr[0] = 5'd9;
        we       = 2'b01;
        waddr[0] = 5'd3;
        wdata[0] = 64'h5555;
        tick();
        raddr[0] = 5'd3;
        wdata[0] = 64'h1234;
        #1;
        chk("old_val_c", bus0.rdata_o[0], 64'h5555);
        tick();
        we = 2'b00;
        #1;
        chk("bypass_s", bus1.rdata_o[0], 64'h1234);
        chk("new_val_c", bus0.rdata_o[0], 64'h1234);

        raddr[0] = 5'd0;
        raddr[1] = 5'd5;
        we       = 2'b01;
        waddr[0] = 5'd0;
        wdata[0] = 64'hFFFF;
        tick();
        we = 2'b00;
        #1;
        chk("r0_c", bus0.rdata_o[0], 64'hFFFF);
        chk("r0_s", bus1.rdata_o[0], 64'hFFFF);
        chk("r0_zero", bus2.rdata_o[0], 64'd0);
        chk("r5_zero", bus2.rdata_o[1], 64'hBBBB);

        clear    = 1'b1;
        we       = 2'b01;
        waddr[0] = 5'd9;
        wdata[0] = 64'h99;
        tick();
        clear = 1'b0;
        chk("clr_fall_c", 64'(bus0.init_done_o), 64'd0);
        chk("clr_fall_s", 64'(bus1.init_done_o), 64'd0);
        chk("clr_fall_z", 64'(bus2.init_done_o), 64'd0);
        waddr[0] = 5'd10;
        wdata[0] = 64'hDEAD;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("clr_busy", 64'(bus0.init_done_o), 64'd0);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        scrub_wait("clr2");
        we = 2'b00;
        readback_zero("post_clr");

        we       = 2'b01;
        waddr[0] = 5'd12;
        wdata[0] = 64'hC0DE;
        raddr[0] = 5'd12;
        tick();
        we = 2'b00;
        #1;
        chk("traffic_c", bus0.rdata_o[0], 64'hC0DE);
        chk("traffic_s", bus1.rdata_o[0], 64'hC0DE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_done", 64'(bus0.init_done_o), 64'd0);
        chk("arst_rd_c", bus0.rdata_o[0], 64'd0);
        chk("arst_rd_s", bus1.rdata_o[0], 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_mid_done", 64'(bus0.init_done_o), 64'd0);
        chk("arst_mid_rd", bus1.rdata_o[0], 64'd0);
        tick();
        rst_n = 1'b1;
        scrub_wait("rst3");
        readback_zero("post_rst3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
